// File: rtl/sright_shifter_n.sv
// Multi-channel sequential signed/unsigned right shifter, STEP bits per cycle.
// Optional round-half-up in arithmetic mode: define SRIGHT_SHIFTER_N_ROUND_EN.
module sright_shifter_n #(
  parameter int BW   = 16,
  parameter int CH   = 2,
  parameter int AW   = 5,
  parameter int STEP = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Mode,
  input  logic [CH*BW-1:0] IN,
  input  logic [AW-1:0]    Amount,
  output logic [CH*BW-1:0] OUT,
  output logic             Busy,
  output logic             End
);

  localparam int RW = $clog2(BW + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [CH*BW-1:0] sh_q, sh_d;
  logic [CH*BW-1:0] out_q, out_d;
  logic             mode_q, mode_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             end_q, end_d;
`ifdef SRIGHT_SHIFTER_N_ROUND_EN
  logic [CH-1:0]    round_q, round_d;
  logic [CH-1:0]    last_w;
`endif

  logic [RW-1:0]    eff;
  logic [RW-1:0]    step_s;
  logic [BW-1:0]    shifted_w [CH];
  logic [BW-1:0]    result_w  [CH];

  assign eff    = (Amount >= AW'(BW)) ? RW'(BW) : RW'(Amount);
  assign step_s = (rem_q > RW'(STEP)) ? RW'(STEP) : rem_q;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [BW-1:0]        word;
    logic signed [BW-1:0] asr;
    logic [BW-1:0]        lsr;

    assign word = sh_q[c*BW +: BW];
    // Separate signed/unsigned shifts keep the mux from forcing an unsigned >>>.
    assign asr  = $signed(word) >>> step_s;
    assign lsr  = word >> step_s;
    assign shifted_w[c] = mode_q ? asr : lsr;

`ifdef SRIGHT_SHIFTER_N_ROUND_EN
    logic [BW-1:0] pre;
    assign pre         = word >> (step_s - RW'(1));
    assign last_w[c]   = pre[0];
    assign result_w[c] = word + BW'(mode_q & round_q[c]);
`else
    assign result_w[c] = word;
`endif
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    out_d   = out_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    end_d   = 1'b0;
`ifdef SRIGHT_SHIFTER_N_ROUND_EN
    round_d = round_q;
`endif
    case (state_q)
      IDLE: begin
        if (Start) begin
          sh_d    = IN;
          mode_d  = Mode;
          rem_d   = eff;
          busy_d  = 1'b1;
`ifdef SRIGHT_SHIFTER_N_ROUND_EN
          round_d = '0;
`endif
          state_d = (eff != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        for (int unsigned c = 0; c < CH; c++) begin
          sh_d[c*BW +: BW] = shifted_w[c];
        end
`ifdef SRIGHT_SHIFTER_N_ROUND_EN
        round_d = last_w;
`endif
        rem_d   = rem_q - step_s;
        state_d = (rem_q == step_s) ? DONE : SHIFT;
      end
      DONE: begin
        for (int unsigned c = 0; c < CH; c++) begin
          out_d[c*BW +: BW] = result_w[c];
        end
        end_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      out_q   <= '0;
      mode_q  <= 1'b0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      end_q   <= 1'b0;
`ifdef SRIGHT_SHIFTER_N_ROUND_EN
      round_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      out_q   <= out_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      end_q   <= end_d;
`ifdef SRIGHT_SHIFTER_N_ROUND_EN
      round_q <= round_d;
`endif
    end
  end

  assign OUT  = out_q;
  assign Busy = busy_q;
  assign End  = end_q;

endmodule

// File: tb/tb_sright_shifter_n.sv
// Scoreboard bench for sright_shifter_n (STEP=1 main instance, STEP=4 side instance).
module tb_sright_shifter_n;

  localparam int BW = 16;
  localparam int CH = 2;
  localparam int AW = 5;

  logic          Clock = 1'b0;
  logic          Reset, Start, Start4, Mode;
  logic [31:0]   IN;
  logic [AW-1:0] Amount;
  logic [31:0]   OUT, OUT4;
  logic          Busy, End, Busy4, End4;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] out;
    int          lat;
    int          t0;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  sright_shifter_n #(.BW(BW), .CH(CH), .AW(AW), .STEP(1)) u_dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Mode(Mode), .IN(IN),
    .Amount(Amount), .OUT(OUT), .Busy(Busy), .End(End)
  );

  sright_shifter_n #(.BW(BW), .CH(CH), .AW(AW), .STEP(4)) u_dut4 (
    .Clock(Clock), .Reset(Reset), .Start(Start4), .Mode(Mode), .IN(IN),
    .Amount(Amount), .OUT(OUT4), .Busy(Busy4), .End(End4)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  function automatic logic [BW-1:0] ref_ch(logic [BW-1:0] x, int amt, logic m);
    int eff;
    int v;
    eff = (amt > BW) ? BW : amt;
    if (m) v = int'($signed(x)) >>> eff;
    else   v = int'({16'b0, x}) >> eff;
`ifdef SRIGHT_SHIFTER_N_ROUND_EN
    if (m && eff > 0) v = v + int'(x[eff-1]);
`endif
    return v[BW-1:0];
  endfunction

  function automatic logic [31:0] ref_out(logic [31:0] x, int amt, logic m);
    logic [31:0] r;
    for (int c = 0; c < CH; c++) r[c*BW +: BW] = ref_ch(x[c*BW +: BW], amt, m);
    return r;
  endfunction

  function automatic int ref_lat(int amt, int step);
    int eff;
    eff = (amt > BW) ? BW : amt;
    return (eff + step - 1) / step + 1;
  endfunction

  // Scoreboard consumer: every End pops one expected result.
  always @(negedge Clock) begin
    if (End === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_end: End=1 with no operation outstanding");
      end else begin
        mon_e = exp_q.pop_front();
        if (OUT !== mon_e.out) begin
          n_fail++;
          $display("FAIL sb_out: got %h expected %h", OUT, mon_e.out);
        end
        n_checks++;
        if (cyc - mon_e.t0 != mon_e.lat) begin
          n_fail++;
          $display("FAIL sb_latency: got %0d expected %0d", cyc - mon_e.t0, mon_e.lat);
        end
        n_checks++;
        if (Busy !== 1'b0) begin
          n_fail++;
          $display("FAIL sb_busy_at_end: got %b expected 0", Busy);
        end
      end
    end
  end

  task automatic drive(input logic [31:0] x, input int amt, input logic m);
    Start  = 1'b1;
    IN     = x;
    Amount = AW'(amt);
    Mode   = m;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    exp_q.push_back('{out: ref_out(x, amt, m), lat: ref_lat(amt, 1), t0: cyc});
    n_checks++;
    if (Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_start: got %b expected 1", Busy);
    end
  endtask

  task automatic wait_end();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      if (End === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL end_timeout: got no End expected End within 40 cycles");
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Start4 = 1'b0; Mode = 1'b0; IN = '0; Amount = '0;
    repeat (3) @(posedge Clock);
    #1;
    n_checks++;
    if ({OUT, Busy, End} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got OUT=%h Busy=%b End=%b expected all 0", OUT, Busy, End);
    end
    n_checks++;
    if ({OUT4, Busy4, End4} !== '0) begin
      n_fail++;
      $display("FAIL reset_state4: got OUT=%h Busy=%b End=%b expected all 0", OUT4, Busy4, End4);
    end
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic test_arith();
    @(negedge Clock);
    drive(32'h8000_7FFF, 4, 1'b1);
    wait_end();
    n_checks++;
`ifdef SRIGHT_SHIFTER_N_ROUND_EN
    if (OUT !== 32'hF800_0800) begin
`else
    if (OUT !== 32'hF800_07FF) begin
`endif
      n_fail++;
      $display("FAIL arith_literal: got %h", OUT);
    end
  endtask

  task automatic test_clamp();
    @(negedge Clock);
    drive(32'h0000_8001, 31, 1'b0);
    wait_end();
    n_checks++;
    if (OUT !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL clamp_logical: got %h expected 00000000", OUT);
    end
    @(negedge Clock);
    drive(32'h0000_8001, 31, 1'b1);
    wait_end();
  endtask

  task automatic test_abort_reset();
    bit saw;
    @(negedge Clock);
    drive(32'h4321_8765, 8, 1'b1);
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b1;
    #2;
    exp_q.delete();
    n_checks++;
    if ({OUT, Busy, End} !== '0) begin
      n_fail++;
      $display("FAIL abort_state: got OUT=%h Busy=%b End=%b expected all 0", OUT, Busy, End);
    end
    @(negedge Clock);
    Reset = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge Clock);
      if (End === 1'b1) saw = 1'b1;
    end
    n_checks++;
    if (saw) begin
      n_fail++;
      $display("FAIL abort_no_end: got End pulse expected none");
    end
    @(negedge Clock);
    drive(32'h4321_8765, 8, 1'b1);
    wait_end();
  endtask

  task automatic test_handshake();
    bit saw;
    @(negedge Clock);
    drive(32'h1234_ABCD, 4, 1'b1);
    @(negedge Clock);
    Start = 1'b1; IN = 32'hFFFF_FFFF; Amount = '0; Mode = 1'b0;
    @(negedge Clock);
    Start = 1'b0;
    wait_end();
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      if (End === 1'b1) saw = 1'b1;
    end
    n_checks++;
    if (saw) begin
      n_fail++;
      $display("FAIL ignored_start: got extra End expected none");
    end
  endtask

  task automatic test_back_to_back();
    @(negedge Clock);
    drive(32'h00F0_0F00, 3, 1'b0);
    wait_end();
    drive(32'hCAFE_BEEF, 0, 1'b1);
    wait_end();
    n_checks++;
    if (OUT !== 32'hCAFE_BEEF) begin
      n_fail++;
      $display("FAIL b2b_passthru: got %h expected cafebeef", OUT);
    end
  endtask

  task automatic test_round();
    @(negedge Clock);
    drive(32'h0000_0003, 1, 1'b1);
    wait_end();
    @(negedge Clock);
    drive(32'h0000_FFFD, 1, 1'b1);
    wait_end();
    n_checks++;
`ifdef SRIGHT_SHIFTER_N_ROUND_EN
    if (OUT[15:0] !== 16'hFFFF) begin
`else
    if (OUT[15:0] !== 16'hFFFE) begin
`endif
      n_fail++;
      $display("FAIL round_neg_literal: got %h", OUT[15:0]);
    end
  endtask

  task automatic test_step4();
    int  t0;
    bit  got;
    @(negedge Clock);
    Start4 = 1'b1; IN = 32'h0000_1234; Amount = AW'(6); Mode = 1'b1;
    @(posedge Clock);
    #1;
    t0 = cyc;
    Start4 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (End4 === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!got || cyc - t0 != ref_lat(6, 4)) begin
      n_fail++;
      $display("FAIL step4_latency: got %0d (seen=%0b) expected %0d", cyc - t0, got, ref_lat(6, 4));
    end
    n_checks++;
    if (OUT4 !== ref_out(32'h0000_1234, 6, 1'b1)) begin
      n_fail++;
      $display("FAIL step4_out: got %h expected %h", OUT4, ref_out(32'h0000_1234, 6, 1'b1));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      @(negedge Clock);
      drive($urandom, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      wait_end();
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_clamp();
    test_abort_reset();
    test_handshake();
    test_back_to_back();
    test_round();
    test_step4();
    test_random();
    repeat (3) @(negedge Clock);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d outstanding expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
